// File: rtl/cpu8_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu8_pkg
// Purpose : Shared definitions for the 8-bit CPU RAM path. Holds the default
//           RAM address/data widths, the external request record and the
//           occupancy state encoding of the external request buffer.
// Revision: 1.0 - initial release
// ============================================================================
package cpu8_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // External request record at the default widths: {we, addr, wdata}.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } ext_req_t;

  // Occupancy of the request buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_PART  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

endpackage : cpu8_pkg
`default_nettype wire

// File: rtl/req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : req_fifo
// Purpose : Synchronous FIFO buffering external RAM requests. Occupancy is
//           tracked by an EMPTY/PART/FULL state machine alongside the count;
//           full/empty come straight from the registered state.
// Ports   : clk, rst_n      clock / async active-low reset
//           push, din       write side (ignored while full)
//           pop, dout       read side, dout is the head entry (ignored while empty)
//           full, empty     occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module req_fifo
  import cpu8_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  occ_state_t       r_state;

  logic w_push;
  logic w_pop;

  assign w_push = push && (r_state != OCC_FULL);
  assign w_pop  = pop  && (r_state != OCC_EMPTY);

  assign full  = (r_state == OCC_FULL);
  assign empty = (r_state == OCC_EMPTY);
  assign dout  = r_mem[r_rd_ptr];

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= OCC_EMPTY;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        OCC_EMPTY: begin
          if (w_push) r_state <= OCC_PART;
        end
        OCC_PART: begin
          if (w_push && !w_pop && (r_count == CNT_FULL - CNT_W'(1)))
            r_state <= OCC_FULL;
          else if (w_pop && !w_push && (r_count == CNT_W'(1)))
            r_state <= OCC_EMPTY;
        end
        OCC_FULL: begin
          // Push is blocked while full, so a pop always leaves a partial buffer.
          if (w_pop) r_state <= OCC_PART;
        end
        default: r_state <= OCC_EMPTY;
      endcase
    end
  end

endmodule : req_fifo
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_port_arbiter
// Purpose : Shares a single-port data RAM between the CPU control path and an
//           external loader/debug port. CPU accesses are never stalled; ext
//           requests are buffered and issued in cycles the CPU leaves idle.
// Ports   : clk, rst_n                       clock / async active-low reset
//           cpu_ram_en/write/read, cpu_addr,
//           cpu_wdata, cpu_rdata             CPU side (rdata is a passthrough)
//           ext_valid/ready, ext_we, ext_addr,
//           ext_wdata                        ext request handshake
//           rsp_valid, rsp_data              ext read response, 1 cycle after issue
//           ram_en/we/addr/wdata, ram_rdata  RAM macro (1-cycle sync read)
//           grant_ext                        ext request issued this cycle
//           starve                           ext blocked >= STARVE_LIMIT cycles
// Revision: 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import cpu8_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_ram_en,
  input  logic              cpu_ram_write,
  input  logic              cpu_ram_read,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              grant_ext,
  output logic              starve
);

  localparam int REQ_W  = 1 + ADDR_W + DATA_W;
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              w_push_req;
  req_t              w_head;
  logic [REQ_W-1:0]  w_head_bits;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_cpu_we;
  logic [SCNT_W-1:0] w_scnt_nxt;

  logic              r_rsp_valid;
  logic [SCNT_W-1:0] r_scnt;
  logic              r_starve;

  // Ext fields are masked by ext_valid so undriven inputs never reach storage.
  assign w_push_req.we    = ext_valid & ext_we;
  assign w_push_req.addr  = ext_valid ? ext_addr  : '0;
  assign w_push_req.wdata = ext_valid ? ext_wdata : '0;

  assign ext_ready = !w_full;
  assign w_push    = ext_valid && ext_ready;

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_push_req),
    .pop   (grant_ext),
    .dout  (w_head_bits),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head = req_t'(w_head_bits);

  // Both strobes together count as a write; a lone read strobe leaves we low.
  assign w_cpu_we = cpu_ram_write || (cpu_ram_write && cpu_ram_read);

  // CPU first, then the FIFO head; the idle bus is driven to zero.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    grant_ext = 1'b0;
    if (cpu_ram_en) begin
      ram_en    = 1'b1;
      ram_we    = w_cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (!w_empty) begin
      ram_en    = 1'b1;
      ram_we    = w_head.we;
      ram_addr  = w_head.addr;
      ram_wdata = w_head.we ? w_head.wdata : '0;
      grant_ext = 1'b1;
    end
  end

  // Blocked cycles only accumulate while an ext request is actually waiting.
  always_comb begin
    w_scnt_nxt = r_scnt;
    if (grant_ext)
      w_scnt_nxt = '0;
    else if (cpu_ram_en && !w_empty && (r_scnt != SCNT_MAX))
      w_scnt_nxt = r_scnt + SCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_scnt      <= '0;
      r_starve    <= 1'b0;
    end else begin
      r_rsp_valid <= grant_ext && !w_head.we;
      r_scnt      <= w_scnt_nxt;
      r_starve    <= (w_scnt_nxt == SCNT_MAX);
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_valid ? ram_rdata : '0;
  assign cpu_rdata = ram_rdata;
  assign starve    = r_starve;

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_port_arbiter
// Purpose : Self-checking bench for ram_port_arbiter. A behavioural RAM sits on
//           the RAM port; a queue-based reference model predicts every output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;
  import cpu8_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int LIMIT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_ram_en, cpu_ram_write, cpu_ram_read;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ext_valid, ext_ready, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          grant_ext, starve;

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ram_en(cpu_ram_en), .cpu_ram_write(cpu_ram_write), .cpu_ram_read(cpu_ram_read),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .grant_ext(grant_ext), .starve(starve)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle synchronous read.
  logic [DW-1:0] ram_mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model state.
  ext_req_t      mq[$];
  logic [DW-1:0] mmem [256];
  int            scnt;
  logic          pend_rsp;
  logic [DW-1:0] pend_data;
  logic          last_rd;
  logic [DW-1:0] last_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_ram_en    = 1'b0;
    cpu_ram_write = 1'b0;
    cpu_ram_read  = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;
    ext_valid     = 1'b0;
    ext_we        = 1'bx;
    ext_addr      = 'x;
    ext_wdata     = 'x;
  endtask

  task automatic model_reset();
    mq.delete();
    scnt     = 0;
    pend_rsp = 1'b0;
    last_rd  = 1'b0;
  endtask

  // One clock cycle: apply inputs, compare all outputs with the model,
  // advance the model across the edge, then park inputs at idle.
  task automatic cycle(input logic c_en, input logic c_we, input logic c_rd,
                       input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                       input logic e_v, input logic e_we,
                       input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd);
    int       qn;
    logic     ready_m;
    logic     issue_m;
    ext_req_t h;
    cpu_ram_en    = c_en;
    cpu_ram_write = c_we;
    cpu_ram_read  = c_rd;
    cpu_addr      = c_addr;
    cpu_wdata     = c_wd;
    ext_valid     = e_v;
    if (e_v) begin
      ext_we = e_we; ext_addr = e_addr; ext_wdata = e_wd;
    end else begin
      ext_we = 1'bx; ext_addr = 'x; ext_wdata = 'x;
    end
    #2;
    qn      = mq.size();
    ready_m = (qn < DEPTH);
    issue_m = !c_en && (qn > 0);
    check("ext_ready", ext_ready, ready_m);
    check("ram_en", ram_en, c_en || (qn > 0));
    check("grant_ext", grant_ext, issue_m);
    if (c_en) begin
      check("cpu_ram_we", ram_we, c_we);
      check("cpu_ram_addr", ram_addr, c_addr);
      if (c_we) check("cpu_ram_wdata", ram_wdata, c_wd);
    end else if (issue_m) begin
      check("ext_ram_we", ram_we, mq[0].we);
      check("ext_ram_addr", ram_addr, mq[0].addr);
      if (mq[0].we) check("ext_ram_wdata", ram_wdata, mq[0].wdata);
    end else begin
      check("idle_ram_we", ram_we, 1'b0);
    end
    check("rsp_valid", rsp_valid, pend_rsp);
    if (pend_rsp) check("rsp_data", rsp_data, pend_data);
    if (last_rd)  check("cpu_rdata", cpu_rdata, last_rd_data);
    check("starve", starve, scnt == LIMIT);

    pend_rsp = 1'b0;
    last_rd  = 1'b0;
    if (c_en) begin
      if (c_we) mmem[c_addr] = c_wd;
      else begin
        last_rd = 1'b1; last_rd_data = mmem[c_addr];
      end
    end else if (issue_m) begin
      h = mq.pop_front();
      if (h.we) mmem[h.addr] = h.wdata;
      else begin
        pend_rsp = 1'b1; pend_data = mmem[h.addr];
        last_rd = 1'b1;  last_rd_data = mmem[h.addr];
      end
    end
    if (issue_m) scnt = 0;
    else if (c_en && (qn > 0) && (scnt < LIMIT)) scnt++;
    if (e_v && ready_m) mq.push_back('{we: e_we, addr: e_addr, wdata: e_wd});

    @(posedge clk);
    #1;
    drive_idle();
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    logic          r_cen, r_cwe, r_crd, r_ev, r_ewe;
    logic [AW-1:0] r_ca, r_ea;
    logic [DW-1:0] r_cd, r_ed;

    for (int i = 0; i < 256; i++) mmem[i] = '0;
    model_reset();
    drive_idle();
    rst_n = 1'b0;

    // Reset values.
    #12;
    check("rst_ext_ready", ext_ready, 1'b1);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_grant", grant_ext, 1'b0);
    check("rst_starve", starve, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_ram_addr", ram_addr, 8'h00);
    check("rst_ram_wdata", ram_wdata, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Ext write then read back with the CPU idle.
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h5A);
    check("wr_issue_en", ram_en, 1'b1);
    check("wr_issue_we", ram_we, 1'b1);
    check("wr_issue_addr", ram_addr, 8'h10);
    check("wr_issue_wdata", ram_wdata, 8'h5A);
    idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    idle_cycle();
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_data", rsp_data, 8'h5A);
    idle_cycle();

    // CPU busy for 4 cycles with an ext read queued in the first.
    cycle(1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h04, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'h05, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    check("busy_grant_c5", grant_ext, 1'b1);
    check("busy_addr_c5", ram_addr, 8'h10);
    idle_cycle();
    check("busy_rsp_valid_c6", rsp_valid, 1'b1);
    check("busy_rsp_data_c6", rsp_data, 8'h5A);
    idle_cycle();

    // Three back-to-back ext requests while the CPU is busy.
    cycle(1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 8'h20, 8'h11);
    cycle(1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 1'b1, 1'b1, 8'h20, 8'h22);
    check("full_ready", ext_ready, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    check("after_pop_ready", ext_ready, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    idle_cycle();
    check("order_rsp_valid", rsp_valid, 1'b1);
    check("order_rsp_data", rsp_data, 8'h22);
    idle_cycle();

    // Starvation: one request pending, CPU busy for 20 cycles.
    cycle(1'b1, 1'b0, 1'b1, 8'h07, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 1'b0, 1'b1, 8'(i), 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check("starve_set", starve, 1'b1);
    idle_cycle();
    check("starve_clr", starve, 1'b0);
    idle_cycle();

    // Reset asserted in the cycle an ext read is issued.
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    check("mid_grant", grant_ext, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_ready", ext_ready, 1'b1);
    check("mid_grant_cleared", grant_ext, 1'b0);
    check("mid_ram_en", ram_en, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    check("mid_rsp_after_edge", rsp_valid, 1'b0);
    rst_n = 1'b1;
    #1;

    // Randomized traffic over a small address window.
    for (int i = 0; i < 600; i++) begin
      r_cen = ($urandom_range(0, 99) < 55);
      r_cwe = 1'($urandom_range(0, 1));
      r_crd = 1'($urandom_range(0, 1));
      r_ca  = 8'($urandom_range(0, 15));
      r_cd  = 8'($urandom);
      r_ev  = ($urandom_range(0, 99) < 50);
      r_ewe = 1'($urandom_range(0, 1));
      r_ea  = 8'($urandom_range(0, 15));
      r_ed  = 8'($urandom);
      cycle(r_cen, r_cwe, r_crd, r_ca, r_cd, r_ev, r_ewe, r_ea, r_ed);
    end
    for (int i = 0; i < 4; i++) idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_port_arbiter
`default_nettype wire
